// File: rtl/systolic_output_collector_if.sv
// systolic_output_collector_if: lane-input and tile-row-output bundle for the systolic output collector
// Signals:
//   lane_data/lane_valid : one result element and strobe per array column (master -> collector)
//   in_ready             : a bank is open for collection (collector -> master)
//   out_row/out_valid    : current tile row and its valid flag (collector -> master)
//   out_ready            : downstream accepts out_row (master -> collector)
//   out_last             : out_row is the final row of the tile
//   err_drop             : sticky flag, an input element was discarded
// COLS and OUTPUT_WIDTH must match the collector instance using this bundle.
interface systolic_output_collector_if #(
    parameter int COLS         = 4,
    parameter int OUTPUT_WIDTH = 16
);
    logic [0:COLS-1][OUTPUT_WIDTH-1:0] lane_data;
    logic [0:COLS-1]                   lane_valid;
    logic                              in_ready;
    logic [0:COLS-1][OUTPUT_WIDTH-1:0] out_row;
    logic                              out_valid;
    logic                              out_ready;
    logic                              out_last;
    logic                              err_drop;

    modport master (
        output lane_data, lane_valid, out_ready,
        input  in_ready, out_row, out_valid, out_last, err_drop
    );

    modport slave (
        input  lane_data, lane_valid, out_ready,
        output in_ready, out_row, out_valid, out_last, err_drop
    );
endinterface

// File: rtl/systolic_output_collector.sv
// systolic_output_collector: ping-pong tile buffer that gathers skewed systolic-array columns and streams rows out
// Ports:
//   clk    : single rising-edge clock
//   rst    : asynchronous active-high reset
//   bus_if : systolic_output_collector_if.slave (lane inputs, row output handshake, in_ready, err_drop)
// Optional build macro SYSTOLIC_COLLECTOR_RELU_EN clamps negative output elements to zero on the read path.
module systolic_output_collector #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int OUTPUT_WIDTH = 16
) (
    input logic                        clk,
    input logic                        rst,
    systolic_output_collector_if.slave bus_if
);
    localparam int CW = $clog2(ROWS + 1);
    localparam int RW = $clog2(ROWS);

    logic [OUTPUT_WIDTH-1:0]           buf_q [2][ROWS][COLS];
    logic [OUTPUT_WIDTH-1:0]           buf_d [2][ROWS][COLS];
    logic [CW-1:0]                     cnt_q [COLS];
    logic [CW-1:0]                     cnt_d [COLS];
    logic [CW-1:0]                     cnt_inc [COLS];
    logic [1:0]                        full_q, full_d;
    logic                              wr_bank_q, wr_bank_d;
    logic                              rd_bank_q, rd_bank_d;
    logic [RW-1:0]                     rd_row_q, rd_row_d;
    logic                              err_q, err_d;
    logic [COLS-1:0]                   wr_en;
    logic                              in_ready, out_valid, last_row, fire, done, drop;
    logic [0:COLS-1][OUTPUT_WIDTH-1:0] out_row;

    // Write side: each lane fills its own column; the tile closes when every
    // column count, including this cycle's writes, has reached ROWS.
    always_comb begin
        in_ready = !full_q[wr_bank_q];
        done     = 1'b1;
        drop     = 1'b0;
        buf_d    = buf_q;
        for (int c = 0; c < COLS; c++) begin
            wr_en[c]   = bus_if.lane_valid[c] && in_ready && (cnt_q[c] < CW'(ROWS));
            drop       = drop || (bus_if.lane_valid[c] && !wr_en[c]);
            cnt_inc[c] = cnt_q[c] + CW'(wr_en[c]);
            done       = done && (cnt_inc[c] == CW'(ROWS));
            if (wr_en[c])
                buf_d[wr_bank_q][cnt_q[c][RW-1:0]][c] = bus_if.lane_data[c];
        end
        for (int c = 0; c < COLS; c++)
            cnt_d[c] = done ? '0 : cnt_inc[c];
        wr_bank_d = wr_bank_q ^ done;
        err_d     = err_q | drop;
    end

    // Read side: a FULL bank is streamed row by row; the final handshake frees it.
    // Completion and freeing always target different banks, so both apply.
    always_comb begin
        out_valid = full_q[rd_bank_q];
        last_row  = rd_row_q == RW'(ROWS - 1);
        fire      = out_valid && bus_if.out_ready;
        full_d    = full_q;
        if (fire && last_row)
            full_d[rd_bank_q] = 1'b0;
        if (done)
            full_d[wr_bank_q] = 1'b1;
        rd_row_d  = fire ? (last_row ? '0 : rd_row_q + RW'(1)) : rd_row_q;
        rd_bank_d = rd_bank_q ^ (fire && last_row);
        for (int c = 0; c < COLS; c++) begin
`ifdef SYSTOLIC_COLLECTOR_RELU_EN
            out_row[c] = buf_q[rd_bank_q][rd_row_q][c][OUTPUT_WIDTH-1] ? '0 : buf_q[rd_bank_q][rd_row_q][c];
`else
            out_row[c] = buf_q[rd_bank_q][rd_row_q][c];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q     <= '{default: '0};
            cnt_q     <= '{default: '0};
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            rd_row_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            rd_row_q  <= rd_row_d;
            err_q     <= err_d;
        end
    end

    assign bus_if.in_ready  = in_ready;
    assign bus_if.out_valid = out_valid;
    assign bus_if.out_last  = out_valid && last_row;
    assign bus_if.out_row   = out_row;
    assign bus_if.err_drop  = err_q;
endmodule

// File: doc/systolic_output_collector.md
Name: systolic_output_collector

Overview:
- Parametrised successor to the square diagonal-wavefront output register: collects skewed result streams from a ROWS x COLS systolic array into a tile buffer.
- Streams the completed tile downstream one row per beat over a valid/ready handshake.
- Two banks (ping-pong): the array fills one tile while the previous tile drains. Sits between the PE array and the result writeback/DMA path.

Parameters:
- ROWS, 4, rows per result tile (>=2)
- COLS, 4, columns per result tile = input lanes (>=2)
- OUTPUT_WIDTH, 16, bits per result element (two's complement)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- lane_data  in  OUTPUT_WIDTH x [0:COLS-1]  result element per array column
- lane_valid  in  [0:COLS-1]  per-lane element strobe
- in_ready  out  1  a bank is open for collection
- out_row  out  OUTPUT_WIDTH x [0:COLS-1]  current tile row
- out_valid  out  1  out_row holds valid data
- out_ready  in  1  downstream accepts out_row
- out_last  out  1  out_row is row ROWS-1 of the tile
- err_drop  out  1  sticky: an input element was discarded

Behaviour:
- Reset (async assert, synchronous release): both banks FREE, wr_bank=0, rd_bank=0, all column counters 0, rd_row=0. Outputs: in_ready=1, out_valid=0, out_last=0, err_drop=0, out_row=0. Buffer contents cleared to 0. A reset mid-tile discards the partial tile and any undrained tile.
- Bank state: each bank is FREE or FULL. Write side fills bank wr_bank only while it is FREE. in_ready = (bank[wr_bank]==FREE).
- Column counters: col_cnt[c], width clog2(ROWS+1). On a clock edge with lane_valid[c]=1, in_ready=1 and col_cnt[c]<ROWS: store lane_data[c] at bank[wr_bank][col_cnt[c]][c], then col_cnt[c]++. Lanes are independent; arbitrary skew between lanes is legal (the array produces element (r,c) at cycle t0+r+c).
- Tile completion: on the edge where all col_cnt reach ROWS (counting this cycle's writes): bank[wr_bank] becomes FULL, wr_bank toggles, all col_cnt reset to 0. Writes on that same edge are the last of the tile. Lane beats on the next cycle target the new bank if it is FREE.
- Drop rules: a lane beat is discarded and err_drop is set (sticky until rst) if in_ready=0, or if col_cnt[c]==ROWS (lane already complete, tile still waiting on other lanes). Beats on other lanes in the same cycle are unaffected.
- Read side:
  - out_valid = (bank[rd_bank]==FULL).
  - out_row = bank[rd_bank][rd_row].
  - out_last = out_valid && rd_row==ROWS-1.
  - On out_valid && out_ready: rd_row++. On the last row, rd_row=0, bank[rd_bank] becomes FREE, and rd_bank toggles.
  - out_row is held stable while out_valid && !out_ready.
- Latency: out_valid rises 1 cycle after the completing write edge. A freed bank raises in_ready 1 cycle after the final out_last handshake.
- Simultaneous events: completion into one bank and freeing of the other on the same edge are both applied. Collection into a bank and draining of the same bank cannot overlap, by construction.
- Throughput: sustained one tile per max(ROWS+COLS-1, ROWS) cycles when out_ready=1.

Optional Feature:
- Macro: SYSTOLIC_COLLECTOR_RELU_EN.
- When defined: each out_row element is clamped at zero on the read path (value<0 -> 0, else unchanged). Stored buffer contents are unmodified.
- When undefined: out_row is the raw stored value. All timing is identical in both builds.

Test Plan:
- ROWS=COLS=4, skewed wavefront, element(r,c)=16*r+c driven at cycle r+c, out_ready=1 -> out_valid rises 1 cycle after element(3,3); rows 0..3 read back in order; out_last on row 3; err_drop=0.
- Two back-to-back tiles with out_ready=0 -> both banks FULL; in_ready=0. A third-tile beat on lane 0 is dropped and err_drop=1. Then out_ready=1 -> tile A drains before tile B; in_ready=1 one cycle after tile A's out_last.
- out_ready toggled 1,0,0,1,... during drain -> out_row stable while stalled; exactly 4 handshakes per tile; no row skipped or repeated.
- Lane 2 sends 5 beats before lane 0 sends any -> 5th beat dropped, err_drop=1. The tile still completes with lane 2 rows 0..3 correct.
- rst asserted mid-tile (2 of 4 rows on every lane written) -> outputs zero immediately. After release, a fresh full tile reads back correctly with no stale data.
- SYSTOLIC_COLLECTOR_RELU_EN build, tile containing -5, 0, 7, 16'h8000 -> out_row shows 0, 0, 7, 0. Non-RELU build shows the raw values.
